// File: rtl/altera_tse_tx_encapsulation.sv
// 1000BASE-X PCS transmit code-group generator (GMII -> unencoded 8b code-groups).
// Define ALTERA_TSE_TX_CARRIER_EXT_EN to enable carrier extension (EXT state).
module altera_tse_tx_encapsulation #(
  parameter bit CFG_SWAP = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  gmii_tx_d,
  input  logic        gmii_tx_en,
  input  logic        gmii_tx_err,
  input  logic [1:0]  xmit,
  input  logic [15:0] config_reg,
  input  logic        tx_disp_pos,
  output logic [7:0]  tx_frame,
  output logic        tx_kchar,
  output logic        tx_even,
  output logic        transmitting
);

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K_S   = 8'hFB;
  localparam logic [7:0] K_T   = 8'hFD;
  localparam logic [7:0] K_R   = 8'hF7;
  localparam logic [7:0] K_V   = 8'hFE;
  localparam logic [7:0] D5_6  = 8'hC5;
  localparam logic [7:0] D16_2 = 8'h50;
  localparam logic [7:0] D21_5 = 8'hB5;
  localparam logic [7:0] D2_2  = 8'h42;

  // state_q names the code-group emitted last; the next one follows from it
  typedef enum logic [3:0] {
    IDLE_K, IDLE_D, CFG_K, CFG_D, CFG_LO, CFG_HI,
    SOP, DATA, EOP_T, EOP_R, EOP_R2
`ifdef ALTERA_TSE_TX_CARRIER_EXT_EN
    , EXT
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  frame_q, frame_d;
  logic        kchar_q, kchar_d;
  logic        even_q;
  logic        trans_q, trans_d;
  logic [15:0] cfg_q, cfg_d;
  logic        sel_q, sel_d;
  logic        first_q, first_d;
  logic        bnd;
`ifdef ALTERA_TSE_TX_CARRIER_EXT_EN
  logic        ext_q, ext_d;
`endif

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    kchar_d = kchar_q;
    trans_d = 1'b0;
    cfg_d   = cfg_q;
    sel_d   = sel_q;
    first_d = first_q;
    bnd     = 1'b0;
`ifdef ALTERA_TSE_TX_CARRIER_EXT_EN
    ext_d   = ext_q;
`endif
    unique case (state_q)
      IDLE_K: begin
        state_d = IDLE_D;
        frame_d = (first_q && tx_disp_pos) ? D5_6 : D16_2;
        kchar_d = 1'b0;
        first_d = 1'b0;
      end
      CFG_K: begin
        state_d = CFG_D;
        frame_d = sel_q ? D2_2 : D21_5;
        kchar_d = 1'b0;
        sel_d   = ~sel_q;
      end
      CFG_D: begin
        state_d = CFG_LO;
        frame_d = CFG_SWAP ? cfg_q[15:8] : cfg_q[7:0];
        kchar_d = 1'b0;
      end
      CFG_LO: begin
        state_d = CFG_HI;
        frame_d = CFG_SWAP ? cfg_q[7:0] : cfg_q[15:8];
        kchar_d = 1'b0;
      end
      SOP, DATA: begin
        trans_d = 1'b1;
        if (gmii_tx_en) begin
          state_d = DATA;
          frame_d = gmii_tx_err ? K_V : gmii_tx_d;
          kchar_d = gmii_tx_err;
        end else begin
          state_d = EOP_T;
          frame_d = K_T;
          kchar_d = 1'b1;
`ifdef ALTERA_TSE_TX_CARRIER_EXT_EN
          ext_d   = gmii_tx_err;
`endif
        end
      end
      EOP_T: begin
`ifdef ALTERA_TSE_TX_CARRIER_EXT_EN
        if (ext_q && gmii_tx_err) begin
          state_d = EXT;
          frame_d = (gmii_tx_d == 8'h0F) ? K_R : K_V;
          kchar_d = 1'b1;
          trans_d = 1'b1;
        end else
`endif
        begin
          state_d = EOP_R;
          frame_d = K_R;
          kchar_d = 1'b1;
          first_d = 1'b1;
        end
      end
`ifdef ALTERA_TSE_TX_CARRIER_EXT_EN
      EXT: begin
        kchar_d = 1'b1;
        if (gmii_tx_err) begin
          frame_d = (gmii_tx_d == 8'h0F) ? K_R : K_V;
          trans_d = 1'b1;
        end else begin
          state_d = EOP_R;
          frame_d = K_R;
          first_d = 1'b1;
        end
      end
`endif
      EOP_R: begin
        // an /R/ on an even slot needs a partner so idle begins even
        if (even_q) begin
          state_d = EOP_R2;
          frame_d = K_R;
          kchar_d = 1'b1;
        end else begin
          bnd = 1'b1;
        end
      end
      IDLE_D, CFG_HI, EOP_R2: bnd = 1'b1;
      default: bnd = 1'b1;
    endcase

    if (bnd) begin
      frame_d = K28_5;
      kchar_d = 1'b1;
      if (xmit == 2'b01) begin
        state_d = CFG_K;
        cfg_d   = config_reg;
        first_d = 1'b0;
      end else if (xmit == 2'b10 && gmii_tx_en && !first_q) begin
        state_d = SOP;
        frame_d = K_S;
        trans_d = 1'b1;
        sel_d   = 1'b0;
      end else begin
        state_d = IDLE_K;
        sel_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE_K;
      frame_q <= K28_5;
      kchar_q <= 1'b1;
      even_q  <= 1'b1;
      trans_q <= 1'b0;
      cfg_q   <= '0;
      sel_q   <= 1'b0;
      first_q <= 1'b0;
`ifdef ALTERA_TSE_TX_CARRIER_EXT_EN
      ext_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      kchar_q <= kchar_d;
      even_q  <= ~even_q;
      trans_q <= trans_d;
      cfg_q   <= cfg_d;
      sel_q   <= sel_d;
      first_q <= first_d;
`ifdef ALTERA_TSE_TX_CARRIER_EXT_EN
      ext_q   <= ext_d;
`endif
    end
  end

  assign tx_frame     = frame_q;
  assign tx_kchar     = kchar_q;
  assign tx_even      = even_q;
  assign transmitting = trans_q;

endmodule

// File: tb/tb_altera_tse_tx_encapsulation.sv
// Bench for altera_tse_tx_encapsulation: random GMII traffic vs slot-indexed
// expected code-group stream built from ordered-set rules.
module tb_altera_tse_tx_encapsulation;

  localparam int N = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  gmii_tx_d = '0;
  logic        gmii_tx_en = 1'b0;
  logic        gmii_tx_err = 1'b0;
  logic [1:0]  xmit = 2'b00;
  logic [15:0] config_reg = '0;
  logic        tx_disp_pos = 1'b0;
  logic [7:0]  tx_frame;
  logic        tx_kchar;
  logic        tx_even;
  logic        transmitting;

  always #4 clk = ~clk;

  altera_tse_tx_encapsulation dut (
    .clk(clk), .reset(reset),
    .gmii_tx_d(gmii_tx_d), .gmii_tx_en(gmii_tx_en),
    .gmii_tx_err(gmii_tx_err), .xmit(xmit),
    .config_reg(config_reg), .tx_disp_pos(tx_disp_pos),
    .tx_frame(tx_frame), .tx_kchar(tx_kchar),
    .tx_even(tx_even), .transmitting(transmitting)
  );

  logic [7:0]  gf [N];
  logic        gk [N];
  logic        gt [N];
  logic        ge [N];
  logic [7:0]  ef [N];
  logic        ek [N];
  logic        et [N];
  logic [7:0]  id [N];
  logic        ierr [N];
  logic        idisp [N];
  logic [15:0] icfg [N];

  int slot = 0;
  int total = 0;
  int bad = 0;
  int last = 0;
  int fs[$];
  int ff[$];
  int fx[$];

  // drive inputs for the next slot, clock once, capture that slot's output
  task automatic drive(input logic [7:0] d, input logic en, input logic err,
                       input logic [1:0] xm, input logic [15:0] cfg,
                       input logic disp);
    gmii_tx_d = d; gmii_tx_en = en; gmii_tx_err = err;
    xmit = xm; config_reg = cfg; tx_disp_pos = disp;
    id[slot+1] = d; ierr[slot+1] = err;
    icfg[slot+1] = cfg; idisp[slot+1] = disp;
    @(posedge clk);
    slot++;
    #1;
    gf[slot] = tx_frame; gk[slot] = tx_kchar;
    gt[slot] = transmitting; ge[slot] = tx_even;
  endtask

  task automatic put(input int s, input logic [7:0] f,
                     input logic k, input logic t);
    ef[s] = f; ek[s] = k; et[s] = t;
  endtask

  task automatic set_idle(input int a, input int b);
    for (int s = a; s <= b; s++)
      if (s % 2 == 0) put(s, 8'hBC, 1'b1, 1'b0);
      else            put(s, 8'h50, 1'b0, 1'b0);
  endtask

  task automatic chk(input int a, input int b, input string tag);
    for (int s = a; s <= b; s++) begin
      total++;
      assert (gf[s] === ef[s] && gk[s] === ek[s] && gt[s] === et[s]
              && ge[s] === (s % 2 == 0))
      else begin
        bad++;
        $error("FAIL %s slot=%0d got=%h k%b t%b e%b exp=%h k%b t%b e%b",
               tag, s, gf[s], gk[s], gt[s], ge[s],
               ef[s], ek[s], et[s], (s % 2 == 0));
      end
    end
  endtask

  task automatic chk_reset(input string tag);
    total++;
    assert (tx_frame === 8'hBC && tx_kchar === 1'b1 && tx_even === 1'b1
            && transmitting === 1'b0)
    else begin
      bad++;
      $error("FAIL %s got=%h k%b e%b t%b exp=bc k1 e1 t0",
             tag, tx_frame, tx_kchar, tx_even, transmitting);
    end
  endtask

  // optional pad to rise parity, frame bytes, then gap (first gap slot = fall)
  task automatic run_frame(input int par, input int len, input bit fixed,
                           input int errpos, input int gap, input int extn);
    logic [7:0] d;
    logic e;
    while (par >= 0 && ((slot + 1) % 2) != par)
      drive(8'($urandom), 1'b0, 1'b0, 2'b10, 16'($urandom), 1'($urandom));
    fs.push_back(slot + 1);
    ff.push_back(slot + 1 + len);
    fx.push_back(extn);
    for (int i = 0; i < len; i++) begin
      d = fixed ? ((i == len - 1) ? 8'hD5 : 8'h55) : 8'($urandom);
      e = (i == errpos) || (!fixed && $urandom_range(0, 5) == 0);
      drive(d, 1'b1, e, 2'b10, 16'($urandom), 1'($urandom));
    end
    for (int i = 0; i < gap; i++) begin
      d = 8'($urandom);
      e = 1'($urandom_range(0, 3) == 0);
`ifdef ALTERA_TSE_TX_CARRIER_EXT_EN
      if (i == 0) e = 1'(extn > 0);
      if (i < extn) begin
        e = 1'b1;
        d = (i < extn - 1) ? 8'h0F : 8'h22;
      end
      if (i == extn) e = 1'b0;
`endif
      drive(d, 1'b0, e, 2'b10, 16'($urandom), 1'($urandom));
    end
  endtask

  // frame rules: /S/ on first allowed even slot, data, /T/, ext, /R/(/R/), idle
  task automatic build_data();
    int s, f, x, p, r, e, blk;
    blk = 0;
    set_idle(36, last);
    for (int j = 0; j < fs.size(); j++) begin
      s = fs[j]; f = ff[j]; x = fx[j];
      p = (s % 2 == 0) ? s : s + 1;
      if (p < blk) p = blk;
      put(p, 8'hFB, 1'b1, 1'b1);
      for (int q = p + 1; q < f; q++)
        put(q, ierr[q] ? 8'hFE : id[q], ierr[q], 1'b1);
      put(f, 8'hFD, 1'b1, 1'b1);
      r = f + ((x > 0) ? x : 1);
      for (int q = f + 1; q < r; q++)
        put(q, (id[q] == 8'h0F) ? 8'hF7 : 8'hFE, 1'b1, 1'b1);
      put(r, 8'hF7, 1'b1, 1'b0);
      e = r + 1;
      if (r % 2 == 0) begin
        put(r + 1, 8'hF7, 1'b1, 1'b0);
        e = r + 2;
      end
      put(e, 8'hBC, 1'b1, 1'b0);
      put(e + 1, idisp[e + 1] ? 8'hC5 : 8'h50, 1'b0, 1'b0);
      blk = e + 2;
    end
  endtask

  task automatic build_cfg();
    int k, pos;
    logic [15:0] c;
    for (int s = 12; s <= 35; s++) begin
      k = (s - 12) / 4;
      pos = (s - 12) % 4;
      c = icfg[12 + 4 * k];
      case (pos)
        0: put(s, 8'hBC, 1'b1, 1'b0);
        1: put(s, (k % 2 == 0) ? 8'hB5 : 8'h42, 1'b0, 1'b0);
        2: put(s, c[7:0], 1'b0, 1'b0);
        default: put(s, c[15:8], 1'b0, 1'b0);
      endcase
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_reset("reset_hold");
    end
    reset = 1'b0;
    slot = 0;

    for (int i = 1; i <= 10; i++)
      drive(8'($urandom), 1'($urandom), 1'($urandom),
            (i <= 5) ? 2'b00 : 2'b11, 16'($urandom), 1'($urandom));

    for (int i = 11; i <= 35; i++)
      drive(8'($urandom), (i < 34) ? 1'($urandom) : 1'b0, 1'($urandom),
            (i < 34) ? 2'b01 : 2'b10,
            (i <= 19) ? 16'h01A0 : 16'($urandom), 1'($urandom));

    run_frame(0, 8, 1'b1, -1, 7, 0);
    run_frame(1, 8, 1'b1, -1, 7, 0);
    run_frame(0, 8, 1'b1, 4, 7, 0);
    for (int i = 0; i < 8; i++)
      run_frame(-1, $urandom_range(4, 16), 1'b0, -1,
                $urandom_range(5, 8), 0);
    run_frame(-1, 8, 1'b0, -1, 1, 0);
    run_frame(-1, 10, 1'b0, -1, 8, 0);
`ifdef ALTERA_TSE_TX_CARRIER_EXT_EN
    run_frame(0, 6, 1'b0, -1, 12, 4);
    run_frame(1, 5, 1'b0, -1, 10, 2);
`endif
    last = slot;

    set_idle(1, 11);
    build_cfg();
    build_data();
    chk(1, 11, "idle");
    chk(12, 35, "config");
    chk(36, last, "data");

    for (int i = 0; i < 4; i++)
      drive(8'h55, 1'b1, 1'b0, 2'b10, 16'h0, 1'b0);
    total++;
    assert (transmitting === 1'b1)
    else begin
      bad++;
      $error("FAIL pre_reset_tx got=%b exp=1", transmitting);
    end
    reset = 1'b1;
    drive(8'h55, 1'b1, 1'b0, 2'b10, 16'h0, 1'b0);
    chk_reset("midframe_reset");
    drive(8'h55, 1'b1, 1'b0, 2'b10, 16'h0, 1'b0);
    chk_reset("midframe_reset2");
    reset = 1'b0;
    slot = 0;
    drive(8'h00, 1'b0, 1'b0, 2'b00, 16'h0, 1'b1);
    ef[1] = 8'h50; ek[1] = 1'b0; et[1] = 1'b0;
    chk(1, 1, "post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
